// File: rtl/arith_seq_unit.sv
// arith_seq_unit: multi-cycle unsigned arithmetic unit behind a start/busy/done
// handshake. ADD, SUB and divide-by-zero finish in one cycle. MUL (shift-add)
// and DIVMOD (restoring) iterate one bit per clock for WIDTH clocks.
module arith_seq_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y_lo,
  output logic [WIDTH-1:0] y_hi,
  output logic             flag
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state, state_next;

  // Working registers shared by both iterative operations:
  //   MUL:    {hi_r,lo_r} is the accumulator, lo_r starts as the multiplier
  //           and shifts out as product bits shift in; aux_r is the multiplicand.
  //   DIVMOD: hi_r is the partial remainder, lo_r starts as the dividend and
  //           fills with quotient bits from the right; aux_r is the divisor.
  logic             div_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] aux_r;
  logic [CW-1:0]    count;

  logic             accept;
  logic             iterative;
  logic             last_step;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_fits;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  // A request is taken whenever the unit is not iterating, including in FIN.
  assign accept    = start && (state != CALC);
  assign iterative = (op == OP_MUL) || ((op != OP_ADD) && (op != OP_SUB) && (b != '0));
  assign last_step = (count == CW'(1));
  assign add_full  = {1'b0, a} + {1'b0, b};
  assign sub_full  = {1'b0, a} - {1'b0, b};

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential logic uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode; busy and done come straight from the state register.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = iterative ? CALC : FIN;
      end
      CALC: begin
        busy = 1'b1;
        if (last_step) state_next = FIN;
      end
      FIN: begin
        done       = 1'b1;
        state_next = start ? (iterative ? CALC : FIN) : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One iteration step of the shift-add multiplier or restoring divider.
  always_comb begin
    mul_sum   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, aux_r} : '0);
    div_shift = {hi_r, lo_r[WIDTH-1]};
    div_fits  = (div_shift >= {1'b0, aux_r});
    if (div_r) begin
      step_hi = div_fits ? WIDTH'(div_shift - {1'b0, aux_r}) : div_shift[WIDTH-1:0];
      step_lo = {lo_r[WIDTH-2:0], div_fits};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_r[WIDTH-1:1]};
    end
  end

  // Operand capture, iteration, and result registers (written only on FIN entry).
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the working registers are reset along with the results; they are
      // only a few flops and this keeps X out of the iteration datapath.
      div_r <= 1'b0;
      hi_r  <= '0;
      lo_r  <= '0;
      aux_r <= '0;
      count <= '0;
      y_lo  <= '0;
      y_hi  <= '0;
      flag  <= 1'b0;
    end else if (accept) begin
      div_r <= op[0];
      case (op)
        OP_ADD: begin
          y_lo <= add_full[WIDTH-1:0];
          y_hi <= {{(WIDTH-1){1'b0}}, add_full[WIDTH]};
          flag <= add_full[WIDTH];
        end
        OP_SUB: begin
          y_lo <= sub_full[WIDTH-1:0];
          y_hi <= {{(WIDTH-1){1'b0}}, sub_full[WIDTH]};
          flag <= sub_full[WIDTH];
        end
        OP_MUL: begin
          hi_r  <= '0;
          lo_r  <= b;
          aux_r <= a;
          count <= CW'(WIDTH);
        end
        default: begin
          if (b == '0) begin
            y_lo <= '1;
            y_hi <= a;
            flag <= 1'b1;
          end else begin
            hi_r  <= '0;
            lo_r  <= a;
            aux_r <= b;
            count <= CW'(WIDTH);
          end
        end
      endcase
    end else if (state == CALC) begin
      hi_r  <= step_hi;
      lo_r  <= step_lo;
      count <= count - CW'(1);
      if (last_step) begin
        y_lo <= step_lo;
        y_hi <= step_hi;
        flag <= div_r ? 1'b0 : (step_hi != '0);
      end
    end
  end

endmodule

// File: tb/tb_arith_seq_unit.sv
// Self-checking bench for arith_seq_unit: directed cases at WIDTH=4, then an
// exhaustive WIDTH=4 sweep and random WIDTH=8 operations against a plain
// arithmetic reference model.
module tb_arith_seq_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, start8;
  logic [1:0] op4, op8;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;
  logic       busy4, done4, flag4, busy8, done8, flag8;
  logic [3:0] y_lo4, y_hi4;
  logic [7:0] y_lo8, y_hi8;

  int    vectors     = 0;
  int    miscompares = 0;
  string ctx         = "init";

  // Last completed result per instance (index 0: WIDTH=4, 1: WIDTH=8).
  logic [7:0] prev_lo [2];
  logic [7:0] prev_hi [2];
  logic       prev_fl [2];

  // Observations from the most recent run_op call.
  int         last_lat;
  logic [7:0] last_lo, last_hi;
  logic       last_fl;

  arith_seq_unit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .op(op4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .y_lo(y_lo4), .y_hi(y_hi4), .flag(flag4)
  );

  arith_seq_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .y_lo(y_lo8), .y_hi(y_hi8), .flag(flag8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s [%s]: observed %0d expected %0d", tag, ctx, obs, expv);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic [1:0] o,
                       input logic [7:0] x, input logic [7:0] y);
    if (w == 4) begin
      start4 = st; op4 = o; a4 = x[3:0]; b4 = y[3:0];
    end else begin
      start8 = st; op8 = o; a8 = x; b8 = y;
    end
  endtask

  task automatic sample(input int w, output logic bz, output logic dn, output logic fl,
                        output logic [7:0] lo, output logic [7:0] hi);
    if (w == 4) begin
      bz = busy4; dn = done4; fl = flag4; lo = {4'b0, y_lo4}; hi = {4'b0, y_hi4};
    end else begin
      bz = busy8; dn = done8; fl = flag8; lo = y_lo8; hi = y_hi8;
    end
  endtask

  // Reference results straight from the arithmetic definition of each op.
  task automatic ref_model(input int w, input logic [1:0] o, input logic [7:0] x,
                           input logic [7:0] y, output logic [7:0] lo,
                           output logic [7:0] hi, output logic fl);
    int unsigned mask = (32'd1 << w) - 32'd1;
    int unsigned xi   = 32'(x);
    int unsigned yi   = 32'(y);
    int unsigned r;
    case (o)
      2'd0: begin
        r  = xi + yi;
        lo = 8'(r & mask);
        hi = 8'(r >> w);
        fl = (r >> w) != 0;
      end
      2'd1: begin
        lo = 8'((xi - yi) & mask);
        fl = xi < yi;
        hi = fl ? 8'd1 : 8'd0;
      end
      2'd2: begin
        r  = xi * yi;
        lo = 8'(r & mask);
        hi = 8'((r >> w) & mask);
        fl = hi != 0;
      end
      default: begin
        if (yi == 0) begin
          lo = 8'(mask); hi = x; fl = 1'b1;
        end else begin
          lo = 8'(xi / yi); hi = 8'(xi % yi); fl = 1'b0;
        end
      end
    endcase
  endtask

  // Issue one operation, follow it to done, and check handshake and results.
  // With hammer set, start is pulsed with junk operands every busy cycle.
  task automatic run_op(input int w, input logic [1:0] o, input logic [7:0] x,
                        input logic [7:0] y, input bit hammer);
    logic [7:0] elo, ehi, lo, hi;
    logic       efl, fl, bz, dn;
    int         exp_lat, cyc, s;
    s = (w == 8) ? 1 : 0;
    ref_model(w, o, x, y, elo, ehi, efl);
    exp_lat = (o == 2'd2 || (o == 2'd3 && y != 8'd0)) ? w + 1 : 1;
    ctx = $sformatf("w%0d op%0d a%0d b%0d", w, o, x, y);
    drive(w, 1'b1, o, x, y);
    @(posedge clk); #1;
    cyc = 1;
    while (1'b1) begin
      sample(w, bz, dn, fl, lo, hi);
      if (dn || cyc >= w + 3) break;
      check("busy", bz, 1);
      check("hold_lo", lo, prev_lo[s]);
      check("hold_hi", hi, prev_hi[s]);
      check("hold_flag", fl, prev_fl[s]);
      if (hammer) drive(w, 1'b1, 2'($urandom), 8'($urandom), 8'($urandom));
      else        drive(w, 1'b0, o, x, y);
      @(posedge clk); #1;
      cyc++;
    end
    drive(w, 1'b0, 2'd0, 8'd0, 8'd0);
    check("done_seen", dn, 1);
    check("latency", cyc, exp_lat);
    check("y_lo", lo, elo);
    check("y_hi", hi, ehi);
    check("flag", fl, efl);
    check("busy_in_fin", bz, 0);
    last_lat = cyc; last_lo = lo; last_hi = hi; last_fl = fl;
    prev_lo[s] = elo; prev_hi[s] = ehi; prev_fl[s] = efl;
    @(posedge clk); #1;
    sample(w, bz, dn, fl, lo, hi);
    check("done_width", dn, 0);
  endtask

  initial begin
    logic [7:0] lo, hi;
    logic       fl, bz, dn, saw;
    int         cyc;

    rst = 1'b1;
    drive(4, 1'b0, 2'd0, 8'd0, 8'd0);
    drive(8, 1'b0, 2'd0, 8'd0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    ctx = "reset";
    for (int w = 4; w <= 8; w += 4) begin
      sample(w, bz, dn, fl, lo, hi);
      check("rst_busy", bz, 0);
      check("rst_done", dn, 0);
      check("rst_lo", lo, 0);
      check("rst_hi", hi, 0);
      check("rst_flag", fl, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      prev_lo[i] = 8'd0; prev_hi[i] = 8'd0; prev_fl[i] = 1'b0;
    end
    @(posedge clk); #1;

    // ADD
    run_op(4, 2'd0, 8'd10, 8'd5, 1'b0);
    check("add_lat", last_lat, 1); check("add_lo", last_lo, 15);
    check("add_hi", last_hi, 0);   check("add_fl", last_fl, 0);
    run_op(4, 2'd0, 8'd15, 8'd1, 1'b0);
    check("addc_lo", last_lo, 0); check("addc_hi", last_hi, 1); check("addc_fl", last_fl, 1);

    // SUB
    run_op(4, 2'd1, 8'd3, 8'd5, 1'b0);
    check("sub_lat", last_lat, 1); check("sub_lo", last_lo, 14);
    check("sub_hi", last_hi, 1);   check("sub_fl", last_fl, 1);
    run_op(4, 2'd1, 8'd12, 8'd4, 1'b0);
    check("sub2_lo", last_lo, 8); check("sub2_fl", last_fl, 0);

    // MUL with start pulsed throughout busy
    run_op(4, 2'd2, 8'd13, 8'd5, 1'b1);
    check("mul_lat", last_lat, 5); check("mul_lo", last_lo, 1);
    check("mul_hi", last_hi, 4);   check("mul_fl", last_fl, 1);
    run_op(4, 2'd2, 8'd15, 8'd15, 1'b1);
    check("mul2_lo", last_lo, 1); check("mul2_hi", last_hi, 14);

    // DIVMOD, including divide by zero
    run_op(4, 2'd3, 8'd13, 8'd5, 1'b0);
    check("div_lat", last_lat, 5); check("div_lo", last_lo, 2);
    check("div_hi", last_hi, 3);   check("div_fl", last_fl, 0);
    run_op(4, 2'd3, 8'd11, 8'd0, 1'b0);
    check("dz_lat", last_lat, 1); check("dz_lo", last_lo, 15);
    check("dz_hi", last_hi, 11);  check("dz_fl", last_fl, 1);

    // Reset two cycles into a MUL
    ctx = "reset_mid_mul";
    drive(4, 1'b1, 2'd2, 8'd7, 8'd9);
    @(posedge clk); #1;
    drive(4, 1'b0, 2'd2, 8'd7, 8'd9);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sample(4, bz, dn, fl, lo, hi);
    check("mrst_busy", bz, 0); check("mrst_done", dn, 0);
    check("mrst_lo", lo, 0);   check("mrst_hi", hi, 0); check("mrst_flag", fl, 0);
    saw = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done4) saw = 1'b1;
    end
    check("mrst_no_done", saw, 0);
    for (int i = 0; i < 2; i++) begin
      prev_lo[i] = 8'd0; prev_hi[i] = 8'd0; prev_fl[i] = 1'b0;
    end

    // Back-to-back: DIVMOD accepted in the FIN cycle of a MUL
    ctx = "b2b";
    drive(4, 1'b1, 2'd2, 8'd3, 8'd3);
    @(posedge clk); #1;
    drive(4, 1'b0, 2'd0, 8'd0, 8'd0);
    cyc = 1;
    while (!done4 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check("b2b_first_lat", cyc, 5);
    check("b2b_first_lo", {4'b0, y_lo4}, 9);
    drive(4, 1'b1, 2'd3, 8'd13, 8'd5);
    @(posedge clk); #1;
    drive(4, 1'b0, 2'd0, 8'd0, 8'd0);
    check("b2b_busy", busy4, 1);
    check("b2b_done_low", done4, 0);
    cyc = 1;
    while (!done4 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check("b2b_gap", cyc, 5);
    check("b2b_lo", {4'b0, y_lo4}, 2);
    check("b2b_hi", {4'b0, y_hi4}, 3);
    check("b2b_flag", flag4, 0);
    @(posedge clk); #1;
    check("b2b_done_width", done4, 0);
    prev_lo[0] = 8'd2; prev_hi[0] = 8'd3; prev_fl[0] = 1'b0;

    // Exhaustive sweep at WIDTH=4
    for (int o = 0; o < 4; o++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          run_op(4, 2'(o), 8'(x), 8'(y), bit'(((x + y) % 3) == 0));

    // Random operations at WIDTH=8
    repeat (2000)
      run_op(8, 2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
